// File: rtl/stream_demux_pkg.sv
// ---------------------------------------------------------------------------
// stream_demux_pkg
// Shared definitions for the packet-aware 1-to-2 stream demultiplexer.
//   state_t          : routing FSM states (IDLE = waiting for a first beat,
//                      PKT = inside a multi-beat packet with a locked target)
//   OUT0 / OUT1      : encodings of the destination select bit
//   DATA_W_DEF       : default data bus width
//   CNT_W_DEF        : default width of the per-output packet counters
// ---------------------------------------------------------------------------
package stream_demux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    localparam logic OUT0 = 1'b0;
    localparam logic OUT1 = 1'b1;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/stream_demux1to2_if.sv
// ---------------------------------------------------------------------------
// stream_demux1to2_if
// Valid/ready stream bundle used on the input and both outputs of the
// demultiplexer.
//   data   : beat payload (DATA_W bits)
//   valid  : beat is present
//   last   : final beat of a packet
//   sel    : destination select on the input side; on an output it carries
//            the fixed index of that output
//   ready  : sink can take the beat this cycle
// Modports:
//   master : the side that produces beats (drives data/valid/last/sel)
//   slave  : the side that consumes beats (drives ready)
// ---------------------------------------------------------------------------
interface stream_demux1to2_if
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [DATA_W-1:0] data;
    logic              valid;
    logic              last;
    logic              sel;
    logic              ready;

    modport master (
        output data,
        output valid,
        output last,
        output sel,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        input  sel,
        output ready
    );

endinterface

// File: rtl/demux_out_slot.sv
// ---------------------------------------------------------------------------
// demux_out_slot
// One-entry registered output stage. A loaded beat is presented on the next
// cycle and held stable until the sink shows ready. Loading while the held
// beat drains in the same cycle is allowed, so the stage sustains one beat
// per cycle; the parent only asserts load when the slot is empty or draining.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : capture load_data/load_last this cycle
//   load_data   : incoming beat data
//   load_last   : incoming beat last marker
//   ready       : downstream sink ready
//   valid       : slot holds a beat
//   data, last  : held beat contents
//   empty       : slot holds no beat (inverse of valid)
// ---------------------------------------------------------------------------
module demux_out_slot
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              last,
    output logic              empty
);

    // Slot register: a load wins over a drain, which lets a new beat replace
    // the one leaving in the same cycle. With no load, ready clears valid and
    // otherwise the beat is held. Data and last only change on a load so
    // they stay stable for as long as valid waits on the sink.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

    assign empty = ~valid;

endmodule

// File: rtl/stream_demux1to2.sv
// ---------------------------------------------------------------------------
// stream_demux1to2
// Packet-aware 1-to-2 stream demultiplexer. The destination is taken from
// in_sel on the first beat of a packet and locked until the packet's last
// beat, so a packet is never split across outputs. Each output has its own
// one-entry slot, and a completed-packet counter that advances when the
// last beat of a packet is accepted for that output.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_if      : input stream (data, valid, last, sel in; ready out)
//   out0_if    : output 0 stream (data, valid, last out; ready in)
//   out1_if    : output 1 stream (data, valid, last out; ready in)
//   busy       : a multi-beat packet is mid-flight
//   pkt_cnt0   : packets completed to output 0 (wraps)
//   pkt_cnt1   : packets completed to output 1 (wraps)
// ---------------------------------------------------------------------------
module stream_demux1to2
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    stream_demux1to2_if.slave   in_if,
    stream_demux1to2_if.master  out0_if,
    stream_demux1to2_if.master  out1_if,
    output logic                busy,
    output logic [CNT_W-1:0]    pkt_cnt0,
    output logic [CNT_W-1:0]    pkt_cnt1
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state;
    logic   sel_q;
    logic   tgt;
    logic   tgt_free;
    logic   accept;
    logic   load0;
    logic   load1;
    logic   empty0;
    logic   empty1;

    // Target selection and input readiness. Only the targeted slot decides
    // whether the input can move, so a stalled sink on the other output never
    // blocks traffic. The sink ready feeds straight through to in_ready so a
    // full slot that is draining this cycle can still take a new beat.
    always_comb begin
        tgt      = OUT0;
        tgt_free = 1'b0;
        if (state == IDLE) begin
            tgt = in_if.sel;
        end else begin
            tgt = sel_q;
        end
        if (tgt == OUT1) begin
            tgt_free = empty1 | out1_if.ready;
        end else begin
            tgt_free = empty0 | out0_if.ready;
        end
    end

    // in_ready is held low while reset is applied.
    assign in_if.ready = rst_n & tgt_free;
    assign accept      = in_if.valid & in_if.ready;
    assign load0       = accept & (tgt == OUT0);
    assign load1       = accept & (tgt == OUT1);

    // Each output reports its own index on the sel lane of its bundle.
    assign out0_if.sel = OUT0;
    assign out1_if.sel = OUT1;

    // Packet-tracking FSM. A non-last first beat locks the destination and
    // enters PKT; the last beat of that packet returns to IDLE. Single-beat
    // packets never leave IDLE. busy is registered alongside the state so it
    // mirrors PKT without a decode after the flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel_q <= OUT0;
            busy  <= 1'b0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (!in_if.last) begin
                        state <= PKT;
                        sel_q <= in_if.sel;
                        busy  <= 1'b1;
                    end
                end
                PKT: begin
                    if (in_if.last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Packet counters advance when a last beat is accepted toward their
    // output, not when it later leaves the slot. They wrap freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            if (load0 && in_if.last) begin
                pkt_cnt0 <= pkt_cnt0 + CNT_ONE;
            end
            if (load1 && in_if.last) begin
                pkt_cnt1 <= pkt_cnt1 + CNT_ONE;
            end
        end
    end

    demux_out_slot #(
        .DATA_W (DATA_W)
    ) u_slot0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load0),
        .load_data (in_if.data),
        .load_last (in_if.last),
        .ready     (out0_if.ready),
        .valid     (out0_if.valid),
        .data      (out0_if.data),
        .last      (out0_if.last),
        .empty     (empty0)
    );

    demux_out_slot #(
        .DATA_W (DATA_W)
    ) u_slot1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load1),
        .load_data (in_if.data),
        .load_last (in_if.last),
        .ready     (out1_if.ready),
        .valid     (out1_if.valid),
        .data      (out1_if.data),
        .last      (out1_if.last),
        .empty     (empty1)
    );

endmodule

// File: doc/stream_demux1to2.md
Name: stream_demux1to2

Overview:
- Packet-aware 1-to-2 stream demultiplexer with valid/ready handshakes on all sides; it is the routing counterpart of the 2:1 select path.
- One input stream is steered to output 0 or output 1 according to a select bit.
- The select is sampled on the first beat of a packet and held until that packet's last beat.
- Each output has a one-entry registered slot and a completed-packet counter.

Parameters:
- DATA_W, 8, width of the data bus.
- CNT_W, 16, width of each per-output packet counter.

Ports:
- clk  in  1  single clock; all registers update on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  DATA_W  input beat data.
- in_valid  in  1  input beat valid.
- in_last  in  1  marks the final beat of a packet.
- in_sel  in  1  destination select (0 = out0, 1 = out1); used only on the first beat of a packet.
- in_ready  out  1  input may be accepted this cycle.
- out0_data  out  DATA_W  output 0 data.
- out0_valid  out  1  output 0 beat valid.
- out0_last  out  1  output 0 last marker.
- out0_ready  in  1  output 0 sink ready.
- out1_data, out1_valid, out1_last  out  DATA_W/1/1  output 1 equivalents of the above.
- out1_ready  in  1  output 1 sink ready.
- busy  out  1  high while a multi-beat packet is mid-flight (state PKT).
- pkt_cnt0  out  CNT_W  packets completed to out0.
- pkt_cnt1  out  CNT_W  packets completed to out1.

Behaviour:
- Reset (rst_n low, asynchronous): all outN_valid/last/data = 0, pkt_cnt0/1 = 0, state = IDLE, busy = 0. in_ready is forced to 0 while rst_n is low.
- Handshake: a transfer occurs when valid & ready are both high on a rising clk edge.
- outN_valid, once high, holds data and last stable until outN_ready is seen.
- Target selection: tgt = in_sel in IDLE; tgt = the latched sel_q in PKT.
- in_ready = ~slot[tgt].valid | outN_ready[tgt]. This is a combinational path from out ready to in_ready; this path is intended.
- The non-target output never affects in_ready.
- Latency: an accepted beat appears on the target output in the cycle after acceptance.
- Throughput: 1 beat/cycle when the sink holds ready high; simultaneous drain and load of a slot in the same cycle is legal.
- FSM IDLE:
  - accept with in_last = 0 -> latch sel_q = in_sel, go to PKT, busy = 1.
  - accept with in_last = 1 -> single-beat packet; stay in IDLE.
- FSM PKT:
  - in_sel is ignored.
  - accept with in_last = 1 -> go to IDLE, busy = 0.
  - accept with in_last = 0 -> stay in PKT.
- Slot register, each cycle:
  - load if the beat is accepted and tgt = N.
  - else clear valid if outN_ready is high.
  - else hold.
- Counters: pkt_cntN increments when an accepted beat with in_last = 1 targets N (counted at input acceptance). Counters wrap modulo 2^CNT_W with no saturation.
- in_valid low: no state change; in_data, in_last and in_sel are don't-care.
- Reset asserted mid-packet: the partial packet is discarded, the FSM returns to IDLE, and both slots are emptied. The next accepted beat is treated as a first beat.
- Both outputs may hold valid beats at the same time (one draining while the other is loaded). This is legal and needs no arbitration.

Decomposition:
- Shared package stream_demux_pkg holds:
  - state enum {IDLE, PKT}.
  - constants OUT0 = 1'b0, OUT1 = 1'b1.
  - default widths (DATA_W = 8, CNT_W = 16).
- Sub-module demux_out_slot is a one-entry registered output stage:
  - inputs: load, data, last, ready.
  - outputs: valid, data, last, empty.
  - instantiated twice.
- Top level holds the FSM, in_ready logic and the two counters.

Test Plan:
- Single-beat packet, IDLE: in_sel = 0, in_data = 0xA5, in_last = 1, out0_ready = 1 -> next cycle out0_valid = 1, out0_data = 0xA5, out0_last = 1; pkt_cnt0 = 1; busy stays 0; out1_valid stays 0.
- Select lock: 3-beat packet 0x11/0x22/0x33 with in_sel = 1 on the first beat, toggled to 0 on beats 2 and 3 -> all three beats appear on out1; busy = 1 after beat 1 and 0 after beat 3; pkt_cnt1 = 1.
- Backpressure: out0_ready = 0, 2-beat packet to out0 -> beat 1 is accepted; in_ready = 0 on beat 2; out0_data holds beat 1 stable. Raise out0_ready -> beat 2 is accepted in the same cycle beat 1 drains.
- Full throughput: 8-beat packet to out0 with out0_ready = 1 throughout -> in_ready stays 1 and exactly one beat per cycle appears on out0. Concurrently the out1 slot holds a stalled beat from an earlier packet, showing independent outputs.
- Reset mid-packet: rst_n pulsed low after beat 2 of 4 -> outputs and counters clear immediately and busy = 0. The next single beat with in_sel = 0 routes to out0.
- Counter wrap with CNT_W = 2: send 5 single-beat packets to out1 -> pkt_cnt1 reads 1, 2, 3, 0, 1.
